// File: rtl/fft_sched_pkg.sv
// Shared constants and helpers for the 8-point FFT frame scheduler.
package fft_sched_pkg;
    localparam int N_PTS          = 8;
    localparam int LOG2_N         = 3;
    localparam int OBUF_DEPTH_DEF = 2;

    function automatic logic [LOG2_N-1:0] bitrev3(input logic [LOG2_N-1:0] i);
        return {i[0], i[1], i[2]};
    endfunction
endpackage

// File: rtl/fft_sched_obuf.sv
// Ping-pong result buffer: captures a whole FFT result in one cycle, replays it one bin per accepted beat.
// FFT_SCHED_BITREV_EN: bins are read from slot bitrev3(m_idx) so they leave in natural frequency order.
module fft_sched_obuf
    import fft_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = OBUF_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_i,
    input  logic [N_PTS*WIDTH-1:0] cap_re_i,
    input  logic [N_PTS*WIDTH-1:0] cap_im_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic [WIDTH-1:0]       m_re_o,
    output logic [WIDTH-1:0]       m_im_o,
    output logic [LOG2_N-1:0]      m_idx_o,
    output logic                   m_last_o,
    output logic                   drain_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

    logic [WIDTH-1:0]  buf_re_q [DEPTH][N_PTS];
    logic [WIDTH-1:0]  buf_im_q [DEPTH][N_PTS];
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [LOG2_N-1:0] idx_q, idx_d, slot;
    logic              beat;

    always_comb begin
        m_valid_o = (occ_q != '0);
        m_last_o  = (idx_q == LOG2_N'(N_PTS - 1));
        beat      = m_valid_o & m_ready_i;
        drain_o   = beat & m_last_o;
        wp_d      = wp_q;
        rp_d      = rp_q;
        occ_d     = occ_q;
        idx_d     = idx_q;
        if (cap_i) begin
            wp_d = (wp_q == PTR_MAX) ? '0 : wp_q + PW'(1);
        end
        // idx is exactly LOG2_N bits, so it wraps 7 -> 0 on the last beat
        if (beat) begin
            idx_d = idx_q + LOG2_N'(1);
        end
        if (drain_o) begin
            rp_d = (rp_q == PTR_MAX) ? '0 : rp_q + PW'(1);
        end
        if (cap_i && !drain_o) begin
            occ_d = occ_q + OW'(1);
        end else if (!cap_i && drain_o) begin
            occ_d = occ_q - OW'(1);
        end
    end

    always_comb begin
`ifdef FFT_SCHED_BITREV_EN
        slot = bitrev3(idx_q);
`else
        slot = idx_q;
`endif
        m_idx_o = idx_q;
        m_re_o  = buf_re_q[rp_q][slot];
        m_im_o  = buf_im_q[rp_q][slot];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            occ_q <= '0;
            idx_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
            idx_q <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_i) begin
            for (int k = 0; k < N_PTS; k++) begin
                buf_re_q[wp_q][k] <= cap_re_i[k*WIDTH +: WIDTH];
                buf_im_q[wp_q][k] <= cap_im_i[k*WIDTH +: WIDTH];
            end
        end
    end
endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the 8-point pipelined FFT: gathers 8 samples, issues when a result slot is
// guaranteed, tracks the fixed pipe latency, and streams results out (FFT_SCHED_BITREV_EN: natural order).
module fft_frame_sched
    import fft_sched_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LAT        = 3,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_re,
    input  logic [WIDTH-1:0]       s_im,
    output logic                   fft_go,
    output logic [N_PTS*WIDTH-1:0] fft_fr,
    output logic [N_PTS*WIDTH-1:0] fft_fi,
    input  logic [N_PTS*WIDTH-1:0] fft_Fr,
    input  logic [N_PTS*WIDTH-1:0] fft_Fi,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_re,
    output logic [WIDTH-1:0]       m_im,
    output logic [LOG2_N-1:0]      m_idx,
    output logic                   m_last,
    output logic                   busy
);
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    localparam logic [CW-1:0]   CRED_MAX = OBUF_DEPTH[CW-1:0];
    localparam logic [LOG2_N:0] FULL     = N_PTS[LOG2_N:0];

    logic [WIDTH-1:0]  ld_re_q [N_PTS];
    logic [WIDTH-1:0]  ld_im_q [N_PTS];
    logic [LOG2_N:0]   in_cnt_q, in_cnt_d;
    logic [CW-1:0]     cred_q, cred_d;
    logic [LAT-1:0]    sr_q, sr_d;
    logic              beat_in;
    logic              drain;

    // A frame draining this cycle frees its slot in time for an issue in the same cycle
    always_comb begin
        s_ready  = (in_cnt_q < FULL);
        beat_in  = s_valid & s_ready;
        fft_go   = (in_cnt_q == FULL) & ((cred_q < CRED_MAX) | drain);
        in_cnt_d = in_cnt_q;
        cred_d   = cred_q;
        if (fft_go) begin
            in_cnt_d = '0;
        end else if (beat_in) begin
            in_cnt_d = in_cnt_q + (LOG2_N+1)'(1);
        end
        if (fft_go && !drain) begin
            cred_d = cred_q + CW'(1);
        end else if (!fft_go && drain) begin
            cred_d = cred_q - CW'(1);
        end
        sr_d = (sr_q << 1) | LAT'(fft_go);
        busy = (in_cnt_q != '0) | (cred_q != '0);
    end

    always_comb begin
        fft_fr = '0;
        fft_fi = '0;
        for (int k = 0; k < N_PTS; k++) begin
            fft_fr[k*WIDTH +: WIDTH] = ld_re_q[k];
            fft_fi[k*WIDTH +: WIDTH] = ld_im_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_cnt_q <= '0;
            cred_q   <= '0;
            sr_q     <= '0;
        end else begin
            in_cnt_q <= in_cnt_d;
            cred_q   <= cred_d;
            sr_q     <= sr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_in) begin
            ld_re_q[in_cnt_q[LOG2_N-1:0]] <= s_re;
            ld_im_q[in_cnt_q[LOG2_N-1:0]] <= s_im;
        end
    end

    fft_sched_obuf #(
        .WIDTH (WIDTH),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .cap_i     (sr_q[LAT-1]),
        .cap_re_i  (fft_Fr),
        .cap_im_i  (fft_Fi),
        .m_ready_i (m_ready),
        .m_valid_o (m_valid),
        .m_re_o    (m_re),
        .m_im_o    (m_im),
        .m_idx_o   (m_idx),
        .m_last_o  (m_last),
        .drain_o   (drain)
    );
endmodule

// File: tb/tb_fft_frame_sched.sv
// Bench for fft_frame_sched: loopback pipe model, cycle table, corner sequences, randomized traffic.
module tb_fft_frame_sched;
    localparam int WIDTH = 8;
    localparam int LAT   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             s_valid = 1'b0;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] s_re = '0;
    logic [WIDTH-1:0] s_im = '0;
    logic             s_ready, fft_go, m_valid, m_last, busy;
    logic [8*WIDTH-1:0] fft_fr, fft_fi, fft_Fr, fft_Fi;
    logic [WIDTH-1:0] m_re, m_im;
    logic [2:0]       m_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8*WIDTH-1:0] lb_re [LAT];
    logic [8*WIDTH-1:0] lb_im [LAT];

    // reference model state: every accepted sample since the last reset, in arrival order
    logic [2*WIDTH-1:0] in_all [$];
    int obeat  = 0;
    int issued = 0;
    int go_cnt = 0;
    int go_cyc [$];
    int last_cyc [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        lb_re[0] <= fft_fr;
        lb_im[0] <= fft_fi;
        for (int i = 1; i < LAT; i++) begin
            lb_re[i] <= lb_re[i-1];
            lb_im[i] <= lb_im[i-1];
        end
    end
    assign fft_Fr = lb_re[LAT-1];
    assign fft_Fi = lb_im[LAT-1];

    fft_frame_sched #(.WIDTH(WIDTH), .LAT(LAT), .OBUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .fft_go(fft_go), .fft_fr(fft_fr), .fft_fi(fft_fi), .fft_Fr(fft_Fr), .fft_Fi(fft_Fi),
        .m_valid(m_valid), .m_ready(m_ready), .m_re(m_re), .m_im(m_im), .m_idx(m_idx),
        .m_last(m_last), .busy(busy)
    );

    function automatic int perm(input int i);
`ifdef FFT_SCHED_BITREV_EN
        int t [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
        int t [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
        return t[i];
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Scoreboard: issued frames and output bins are compared against the accepted-sample history
    always @(negedge clk) begin
        int j;
        int pos;
        if (!rst) begin
            in_all.delete();
            obeat  = 0;
            issued = 0;
        end else begin
            if (s_valid && s_ready) in_all.push_back({s_re, s_im});
            if (fft_go) begin
                go_cnt++;
                go_cyc.push_back(cyc);
                if ((issued + 1) * 8 > in_all.size()) begin
                    note_fail("issue_without_full_frame");
                end else begin
                    for (int k = 0; k < 8; k++) begin
                        chk("issue_re", fft_fr[k*WIDTH +: WIDTH], in_all[issued*8+k][2*WIDTH-1:WIDTH]);
                        chk("issue_im", fft_fi[k*WIDTH +: WIDTH], in_all[issued*8+k][WIDTH-1:0]);
                    end
                end
                issued++;
            end
            if (m_valid && m_ready) begin
                j   = obeat % 8;
                pos = (obeat / 8) * 8 + perm(j);
                if (pos >= in_all.size() || obeat / 8 >= issued) begin
                    note_fail("unexpected_out_beat");
                end else begin
                    chk("out_re", m_re, in_all[pos][2*WIDTH-1:WIDTH]);
                    chk("out_im", m_im, in_all[pos][WIDTH-1:0]);
                    chk("out_idx", m_idx, j);
                    chk("out_last", m_last, (j == 7) ? 1 : 0);
                end
                if (m_last) last_cyc.push_back(cyc);
                obeat++;
            end
        end
    end

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // called at posedge+1; returns at posedge+1 just after the beat was accepted
    task automatic push(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        int n = 0;
        s_valid = 1'b1; s_re = re; s_im = im;
        @(negedge clk);
        while (!s_ready && n < 500) begin @(negedge clk); n++; end
        if (!s_ready) note_fail("push_timeout");
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_beats(input string nm, input int target, input int budget);
        int n = 0;
        while (obeat < target && n < budget) begin @(posedge clk); #1; n++; end
        chk(nm, obeat, target);
    endtask

    typedef struct {
        logic             sv;
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        logic             e_srdy, e_go, e_mv, e_busy, e_last;
        logic [2:0]       e_idx;
        logic [WIDTH-1:0] e_re, e_im;
    } vec_t;
    vec_t tbl [21];

    initial begin
        int b0, g0, n;
        logic done;

        // single frame, m_ready held high: one row per clock cycle
        for (int r = 0; r < 21; r++) begin
            tbl[r] = '{sv: 1'b0, re: '0, im: '0, e_srdy: 1'b1, e_go: 1'b0, e_mv: 1'b0,
                       e_busy: 1'b1, e_last: 1'b0, e_idx: 3'd0, e_re: '0, e_im: '0};
            if (r < 8) begin
                tbl[r].sv = 1'b1;
                tbl[r].re = WIDTH'(r + 1);
                tbl[r].im = WIDTH'(8'hF0 + r);
                tbl[r].e_busy = (r != 0);
            end else if (r == 8) begin
                tbl[r].e_srdy = 1'b0;
                tbl[r].e_go   = 1'b1;
            end else if (r >= 12 && r <= 19) begin
                tbl[r].e_mv   = 1'b1;
                tbl[r].e_idx  = 3'(r - 12);
                tbl[r].e_last = (r == 19);
                tbl[r].e_re   = WIDTH'(perm(r - 12) + 1);
                tbl[r].e_im   = WIDTH'(8'hF0 + perm(r - 12));
            end else if (r == 20) begin
                tbl[r].e_busy = 1'b0;
            end
        end

        // reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fft_go", fft_go, 0);
        chk("rst_m_idx", m_idx, 0);
        chk("rst_m_last", m_last, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", s_ready, 1);
        chk("idle_busy", busy, 0);

        m_ready = 1'b1;
        for (int r = 0; r < 21; r++) begin
            @(posedge clk); #1;
            s_valid = tbl[r].sv; s_re = tbl[r].re; s_im = tbl[r].im;
            @(negedge clk);
            chk("tbl_s_ready", s_ready, tbl[r].e_srdy);
            chk("tbl_fft_go", fft_go, tbl[r].e_go);
            chk("tbl_m_valid", m_valid, tbl[r].e_mv);
            chk("tbl_busy", busy, tbl[r].e_busy);
            chk("tbl_m_idx", m_idx, tbl[r].e_idx);
            chk("tbl_m_last", m_last, tbl[r].e_last);
            if (tbl[r].e_mv) begin
                chk("tbl_m_re", m_re, tbl[r].e_re);
                chk("tbl_m_im", m_im, tbl[r].e_im);
            end
        end

        // backpressure: two frames fill the credits, the third is held
        align();
        m_ready = 1'b0;
        go_cyc.delete();
        g0 = go_cnt;
        b0 = obeat;
        for (int i = 0; i < 24; i++) push(WIDTH'(8'h30 + i), WIDTH'(8'hC0 - i));
        idle(8);
        @(negedge clk);
        chk("bp_go_count", go_cnt - g0, 2);
        chk("bp_hold_s_ready", s_ready, 0);
        chk("bp_hold_fft_go", fft_go, 0);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_busy", busy, 1);
        @(posedge clk); #1;
        last_cyc.delete();
        m_ready = 1'b1;
        n = 0;
        while (go_cnt - g0 < 3 && n < 100) begin @(posedge clk); #1; n++; end
        chk("bp_third_go", go_cnt - g0, 3);
        if (go_cyc.size() >= 3 && last_cyc.size() >= 1) chk("bp_go_at_last", go_cyc[2], last_cyc[0]);
        else note_fail("bp_go_at_last_missing");
        wait_beats("bp_beats", b0 + 24, 300);

        // reset one cycle after an issue drops the in-flight frame
        for (int i = 0; i < 8; i++) push(WIDTH'(8'h21 + i), WIDTH'(8'h81 + i));
        n = 0;
        while (!fft_go && n < 50) begin @(posedge clk); #1; n++; end
        chk("mid_go_seen", fft_go, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_busy_after_rst", busy, 0);
        chk("mid_m_valid_after_rst", m_valid, 0);
        align();
        for (int i = 0; i < 8; i++) push(WIDTH'(8'h11 + i), WIDTH'(8'hE1 + i));
        wait_beats("mid_beats", 8, 100);
        idle(6);
        chk("mid_no_stale", obeat, 8);
        chk("mid_idle_busy", busy, 0);

        // continuous streaming, 10 frames
        b0 = obeat;
        for (int i = 0; i < 80; i++) push(WIDTH'($urandom), WIDTH'($urandom));
        wait_beats("stream_beats", b0 + 80, 200);

        // random valid gaps and random downstream stalls
        b0 = obeat;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 96; i++) begin
                    idle(int'($urandom_range(0, 2)));
                    push(WIDTH'($urandom), WIDTH'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        wait_beats("rand_beats", b0 + 96, 2000);
        idle(6);
        chk("rand_no_extra", obeat, b0 + 96);
        chk("rand_idle_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
